// File: rtl/instr_mem_responder_pkg.sv
// Shared definitions for the instruction-fetch responder: FSM states and
// interface width defaults common with the fetch stage.
package instr_mem_responder_pkg;

  localparam int unsigned ADDR_W_DEF   = 8;
  localparam int unsigned DATA_W_DEF   = 8;
  localparam int unsigned WAIT_MAX     = 15;
  localparam int unsigned WAIT_CNT_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

endpackage

// File: rtl/instr_mem_array.sv
// Program storage: DEPTH x DATA_W words, one write port and one combinational
// read port with write-first bypass. Out-of-range reads return zero.
module instr_mem_array #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_LIM = DEPTH[ADDR_W:0];

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic              w_in_range;
  logic              r_in_range;

  assign w_in_range = {1'b0, waddr} < DEPTH_LIM;
  assign r_in_range = {1'b0, raddr} < DEPTH_LIM;

  always_ff @(posedge clk) begin
    if (we && w_in_range) begin
      mem_q[waddr[IDX_W-1:0]] <= wdata;
    end
  end

  always_comb begin
    rdata = '0;
    if (r_in_range) begin
      rdata = mem_q[raddr[IDX_W-1:0]];
      if (we && (waddr == raddr)) begin
        rdata = wdata;
      end
    end
  end

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction-fetch responder: accepts a PC, waits WAIT_CYCLES, then presents
// the stored instruction (or an out-of-range error) under valid/ready.
module instr_mem_responder
  import instr_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W      = ADDR_W_DEF,
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned DEPTH       = 256,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  if (WAIT_CYCLES > WAIT_MAX) begin : g_bad_wait
    $error("instr_mem_responder: WAIT_CYCLES must be 0..15");
  end
  if (DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("instr_mem_responder: DEPTH exceeds address space");
  end

  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT = WAIT_CYCLES[WAIT_CNT_W-1:0];

  state_e                  state_q, state_d;
  logic [WAIT_CNT_W-1:0]   cnt_q, cnt_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [DATA_W-1:0]       rsp_data_q, rsp_data_d;
  logic                    rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0]       mem_rdata;
  logic                    addr_err;

  instr_mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk   (Clk),
    .we    (ld_en),
    .waddr (ld_addr),
    .wdata (ld_data),
    .raddr (addr_q),
    .rdata (mem_rdata)
  );

  assign addr_err = ({1'b0, addr_q} >= DEPTH[ADDR_W:0]);

  // Every request passes through WAIT (counter starts at WAIT_CYCLES and must
  // reach zero), so the response appears WAIT_CYCLES+1 edges after accept.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    req_ready  = 1'b0;
    rsp_valid  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          cnt_d   = WAIT_INIT;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          rsp_data_d = mem_rdata;
          rsp_err_d  = addr_err;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign rsp_data = rsp_data_q;
  assign rsp_err  = rsp_err_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized scoreboard bench for instr_mem_responder: a driver issues fetches
// and loads against a memory model; a monitor checks every accepted response.
module tb_instr_mem_responder;

  localparam int unsigned TB_W     = 3;
  localparam int unsigned TB_DEPTH = 200;

  logic       Clk;
  logic       Reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_addr;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_err;
  logic       ld_en;
  logic [7:0] ld_addr;
  logic [7:0] ld_data;
  logic       busy;

  instr_mem_responder #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .DEPTH       (TB_DEPTH),
    .WAIT_CYCLES (TB_W)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data),
    .busy      (busy)
  );

  int unsigned n_chk  = 0;
  int unsigned n_fail = 0;
  logic [7:0]  model_mem [256];
  logic [8:0]  exp_q [$];

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance one clock; loads committed at the edge update the model first.
  task automatic tick();
    @(posedge Clk);
    if (Reset && ld_en && (int'(ld_addr) < TB_DEPTH)) model_mem[ld_addr] = ld_data;
    #1;
  endtask

  task automatic random_load(input logic [7:0] a, input bit hit);
    ld_en   = ($urandom_range(0, 2) == 0);
    ld_addr = (hit && $urandom_range(0, 1) == 1) ? a : 8'($urandom);
    ld_data = 8'($urandom);
  endtask

  task automatic do_fetch(input logic [7:0] a, input bit hit);
    int unsigned hold;
    chk("idle_req_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    random_load(a, hit);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i <= int'(TB_W); i++) begin
      chk("wait_busy", 32'(busy), 32'd1);
      chk("wait_req_ready", 32'(req_ready), 32'd0);
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      req_valid = 1'($urandom);
      req_addr  = 8'($urandom);
      rsp_ready = 1'($urandom);
      random_load(a, hit);
      tick();
    end
    req_valid = 1'b0;
    if (int'(a) >= TB_DEPTH) exp_q.push_back({1'b1, 8'h00});
    else                     exp_q.push_back({1'b0, model_mem[a]});
    chk("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    hold = $urandom_range(0, 5);
    repeat (hold) begin
      rsp_ready = 1'b0;
      random_load(a, hit);
      tick();
      chk("resp_req_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    random_load(a, hit);
    tick();
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    chk("post_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("post_req_ready", 32'(req_ready), 32'd1);
    chk("post_busy", 32'(busy), 32'd0);
  endtask

  function automatic logic [7:0] rand_addr();
    if ($urandom_range(0, 4) == 0) return 8'($urandom_range(TB_DEPTH, 255));
    return 8'($urandom_range(0, TB_DEPTH - 1));
  endfunction

  // Monitor: pops on every handshake and checks data is held under backpressure.
  initial begin
    logic       prev_hold;
    logic [8:0] prev_val;
    logic [8:0] exp;
    prev_hold = 1'b0;
    prev_val  = '0;
    forever begin
      @(negedge Clk);
      if (Reset && rsp_valid) begin
        if (prev_hold) chk("rsp_stable", 32'({rsp_err, rsp_data}), 32'(prev_val));
        if (rsp_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_rsp", 32'({rsp_err, rsp_data}), 32'h1ff);
          end else begin
            exp = exp_q.pop_front();
            chk("rsp_data", 32'(rsp_data), 32'(exp[7:0]));
            chk("rsp_err", 32'(rsp_err), 32'(exp[8]));
          end
        end
        prev_hold = !rsp_ready;
        prev_val  = {rsp_err, rsp_data};
      end else begin
        prev_hold = 1'b0;
      end
    end
  end

  initial begin
    Reset     = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    rsp_ready = 1'b0;
    ld_en     = 1'b0;
    ld_addr   = '0;
    ld_data   = '0;
    #3 Reset = 1'b0;
    #2;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_rsp_err", 32'(rsp_err), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;

    for (int a = 0; a < 256; a++) begin
      ld_en   = 1'b1;
      ld_addr = 8'(a);
      ld_data = 8'($urandom);
      tick();
    end
    ld_en = 1'b0;

    for (int n = 0; n < 60; n++) begin
      do_fetch(rand_addr(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    // Reset while the request is still waiting: no response, storage kept.
    req_valid = 1'b1;
    req_addr  = 8'd5;
    tick();
    req_valid = 1'b0;
    tick();
    #2 Reset = 1'b0;
    #1;
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("midrst_req_ready", 32'(req_ready), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_rsp_data", 32'(rsp_data), 32'd0);
    @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    chk("postrst_busy", 32'(busy), 32'd0);
    repeat (TB_W + 3) tick();
    chk("postrst_no_rsp", 32'(rsp_valid), 32'd0);
    do_fetch(8'd5, 1'b0);

    for (int n = 0; n < 20; n++) do_fetch(rand_addr(), 1'b1);

    repeat (4) tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
